// File: rtl/lion_mem_responder.sv
// lion_mem_responder: fixed-latency memory slave with a word RAM and access error flags
module lion_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] req_count
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic instr_q;
  logic [31:0] ram [MEM_WORDS];
  logic [31:0] s_addr, s_wdata, off;
  logic [3:0] s_wstrb;
  logic s_instr, go_resp, err_n, wr;
  logic [AW-1:0] idx;
  // With zero latency the request executes straight from the inputs, otherwise from the latched copy
  always_comb begin
    s_addr = state == IDLE ? mem_addr : addr_q;
    s_wdata = state == IDLE ? mem_wdata : wdata_q;
    s_wstrb = state == IDLE ? mem_wstrb : wstrb_q;
    s_instr = state == IDLE ? mem_instr : instr_q;
    off = s_addr - MEM_BASE;
    idx = off[AW+1:2];
    err_n = (s_addr[1:0] != 2'b00) || ((off >> 2) >= 32'(MEM_WORDS)) || (s_instr && s_wstrb != 4'h0);
    go_resp = mem_valid && ((state == IDLE && LATENCY == 0) || (state == BUSY && cnt == 4'd1));
    wr = go_resp && !reset && !err_n && s_wstrb != 4'h0;
  end
  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clock) begin
    if (wr)
      for (int i = 0; i < 4; i++)
        if (s_wstrb[i]) ram[idx][8*i +: 8] <= s_wdata[8*i +: 8];
  end
  // Handshake FSM with registered response outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_err <= 1'b0;
      req_count <= '0;
    end else begin
      mem_ready <= go_resp;
      mem_err <= go_resp && err_n;
      mem_rdata <= (go_resp && !err_n && s_wstrb == 4'h0) ? ram[idx] : 32'h0;
      case (state)
        IDLE: if (mem_valid) begin
          addr_q <= mem_addr;
          wdata_q <= mem_wdata;
          wstrb_q <= mem_wstrb;
          instr_q <= mem_instr;
          cnt <= 4'(LATENCY);
          state <= LATENCY > 0 ? BUSY : RESP;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          state <= !mem_valid ? IDLE : cnt == 4'd1 ? RESP : BUSY;
        end
        RESP: begin
          req_count <= req_count + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lion_mem_responder.md
Name: lion_mem_responder

Overview:
- Downstream memory slave for the LionFV core's native memory port (mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb in, mem_rdata out).
- Adds a mem_ready handshake with a configurable fixed wait-state count, backed by an internal word-addressed RAM.
- Flags misaligned, out-of-range and illegal (write-to-instruction) accesses.
- Used in simulation benches and bounded formal runs to replace the unconstrained random read-data source with a deterministic memory.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two, at least 4.
- LATENCY, 2, wait cycles between request accept and response; range 0..15.
- MEM_BASE, 32'h0000_0000, byte address of RAM word 0; must be MEM_WORDS*4 aligned.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  request valid; held by the core until mem_ready.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; 0 means read.
- mem_ready  output  1  one-cycle response strobe.
- mem_rdata  output  32  read data; valid only while mem_ready is high.
- mem_err  output  1  error qualifier; valid only while mem_ready is high.
- req_count  output  32  number of completed responses.

Behaviour:
- Reset (async): state=IDLE; mem_ready=0, mem_rdata=0, mem_err=0, req_count=0; latched request regs cleared. RAM contents are not reset.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If mem_valid=1: latch addr, wdata, wstrb, instr; load wait counter with LATENCY.
  - Go to BUSY if LATENCY>0, else RESP.
- BUSY:
  - Decrement the counter each cycle; when it reaches 1 and mem_valid=1, go to RESP.
  - If mem_valid=0 in any BUSY cycle (protocol abort): go to IDLE. No RAM write, no mem_ready, req_count unchanged.
- RESP (one cycle):
  - mem_ready=1.
  - Execute the latched request: the RAM read/write is performed in the cycle that enters RESP, so outputs are registered.
  - Next state is always IDLE.
- Latency: mem_ready rises exactly LATENCY+1 cycles after the first cycle mem_valid is sampled high in IDLE.
- Back-to-back requests: after RESP, the earliest next accept is the following IDLE cycle. Minimum request period is LATENCY+2 cycles.
- Error classification, on latched values:
  - mem_addr[1:0] != 0 → misaligned.
  - (mem_addr - MEM_BASE) >> 2 >= MEM_WORDS, using 32-bit unsigned arithmetic so addresses below base wrap high → out-of-range.
  - mem_instr=1 with mem_wstrb != 0 → illegal.
  - Any of these: mem_err=1, mem_rdata=0, no RAM write.
- Read (wstrb=0, no error): mem_rdata = RAM[index], mem_err=0.
- Write (no error):
  - For each i with wstrb[i]=1, RAM[index][8i+7:8i] = wdata[8i+7:8i]; other bytes are unchanged.
  - mem_rdata = 0, mem_err=0.
- mem_rdata and mem_err return to 0 in the cycle after RESP.
- req_count increments by 1 on every RESP cycle, including errored responses; it wraps from 2^32-1 to 0.
- Reset asserted mid-operation: immediately return to IDLE with outputs cleared. A pending write is discarded; a write already committed stays in RAM.
- Inputs that change while in BUSY (other than mem_valid) are ignored; the latched copy is used.

Test Plan:
- LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10 → each mem_ready 3 cycles after valid; read returns 0xDEADBEEF, mem_err=0, req_count=2.
- Byte strobes: write 0x11223344 to 0x20, then wstrb 4'b0010 wdata 0x0000AA00 → read returns 0x1122AA44.
- Errors: read 0x22 (misaligned) → mem_err=1, mem_rdata=0. Read MEM_BASE+MEM_WORDS*4 → mem_err=1. Fetch (mem_instr=1) with wstrb 4'hF → mem_err=1 and RAM unchanged on re-read.
- LATENCY=0 back-to-back reads held continuously valid → mem_ready on every 2nd cycle; req_count increments per response.
- Abort: drop mem_valid in the 2nd BUSY cycle of a write → no mem_ready, subsequent read shows old data. Assert reset during BUSY → mem_ready=0 and req_count=0 next cycle, FSM accepts a new request after reset release.
- Wrap: force req_count to 32'hFFFF_FFFF (bench hierarchy poke), complete one read → req_count=0.
